// File: rtl/anim_pkg.sv
// -----------------------------------------------------------------------------
// anim_pkg
// Shared definitions for the LCD face animation path: panel geometry,
// animation timing, expression codes and the scheduler state encoding.
// Imported by expression_scheduler, frame_start_detect, the pixel mux and the
// LCD top so every block agrees on the same constants.
// -----------------------------------------------------------------------------
package anim_pkg;

  // Panel geometry (pixels)
  localparam int LCD_W             = 132;
  localparam int LCD_H             = 162;

  // Animation timing (frames)
  localparam int HOLD_FRAMES       = 8;
  localparam int NUM_STEPS         = 4;
  localparam int IDLE_BLINK_FRAMES = 120;

  // Counter widths: $clog2 of the limit, never narrower than one bit
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int IDLE_W = (IDLE_BLINK_FRAMES > 1) ? $clog2(IDLE_BLINK_FRAMES) : 1;

  // Expression source codes driven onto the pixel mux select
  typedef enum logic [1:0] {
    EXPR_IDLE  = 2'd0,
    EXPR_SMILE = 2'd1,
    EXPR_BLINK = 2'd2,
    EXPR_SLEEP = 2'd3
  } expr_e;

  // Scheduler states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_PLAY   = 2'd2,
    S_RETURN = 2'd3
  } state_e;

endpackage

// File: rtl/frame_start_detect.sv
// -----------------------------------------------------------------------------
// frame_start_detect
// Watches the LCD driver fetch address and flags the start of each frame: the
// address is (0,0) now and was not (0,0) on the previous cycle, so a dwell at
// the origin yields a single event. Events are suppressed while i_go is low.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_go           : run enable; 0 suppresses frame events
//   i_pix_x/i_pix_y: current fetch column / row
//   o_frame_start  : combinational frame-start condition (for same-edge updates
//                    in frame-synchronous logic)
//   o_frame_tick   : registered one-cycle pulse, the cycle after (0,0) is seen
// -----------------------------------------------------------------------------
module frame_start_detect
  import anim_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_go,
  input  logic [7:0] i_pix_x,
  input  logic [7:0] i_pix_y,
  output logic       o_frame_start,
  output logic       o_frame_tick
);

  logic w_at_origin;
  logic r_prev_origin;
  logic r_frame_tick;

  assign w_at_origin   = (i_pix_x == 8'd0) && (i_pix_y == 8'd0);
  assign o_frame_start = w_at_origin && !r_prev_origin && i_go;
  assign o_frame_tick  = r_frame_tick;

  // Previous-address tracker and registered frame tick. The tracker resets to
  // "at origin" so the first (0,0) after reset is not taken as a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_origin <= 1'b1;
      r_frame_tick  <= 1'b0;
    end else begin
      r_prev_origin <= w_at_origin;
      r_frame_tick  <= o_frame_start;
    end
  end

endmodule

// File: rtl/expression_scheduler.sv
// -----------------------------------------------------------------------------
// expression_scheduler
// Sequences the LCD face animation. Accepts expression requests on a
// valid/ready handshake and switches the pixel-mux source only at frame
// starts, so a frame never mixes two expressions. With no request for
// IDLE_BLINK_FRAMES frames it plays an automatic BLINK.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_go                : run enable; 0 freezes all frame-driven progress
//   i_req_valid         : request valid (held by requester until accepted)
//   i_req_expr          : requested expression code (expr_e)
//   o_req_ready         : ready, high only in S_IDLE (state decode)
//   i_pix_x, i_pix_y    : LCD fetch address
//   o_src_sel           : expression source for the pixel mux
//   o_frame_idx         : animation step within the selected expression
//   o_frame_tick        : one-cycle pulse per frame start
//   o_busy              : high in any state other than S_IDLE
//   o_done              : one-cycle pulse when an animation completes
// -----------------------------------------------------------------------------
module expression_scheduler
  import anim_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_go,
  input  logic       i_req_valid,
  input  logic [1:0] i_req_expr,
  output logic       o_req_ready,
  input  logic [7:0] i_pix_x,
  input  logic [7:0] i_pix_y,
  output logic [1:0] o_src_sel,
  output logic [3:0] o_frame_idx,
  output logic       o_frame_tick,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BLINK_FRAMES - 1);
  localparam logic [3:0]        STEP_LAST = 4'(NUM_STEPS - 1);

  logic              w_frame_start;
  logic              w_handshake;

  state_e            r_state;
  expr_e             r_expr;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [1:0]        r_src_sel;
  logic [3:0]        r_frame_idx;
  logic              r_busy;
  logic              r_done;

  frame_start_detect u_frame_start_detect (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_go          (i_go),
    .i_pix_x       (i_pix_x),
    .i_pix_y       (i_pix_y),
    .o_frame_start (w_frame_start),
    .o_frame_tick  (o_frame_tick)
  );

  assign o_req_ready = (r_state == S_IDLE);
  assign w_handshake = i_req_valid && o_req_ready;

  assign o_src_sel   = r_src_sel;
  assign o_frame_idx = r_frame_idx;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  // Scheduler FSM with registered outputs. All progress is keyed on the
  // combinational frame-start so src_sel/frame_idx move on the same edge that
  // raises frame_tick, ahead of the first fetch of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_expr      <= EXPR_IDLE;
      r_idle_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_src_sel   <= 2'd0;
      r_frame_idx <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A non-idle request pre-empts an idle blink due on the same edge
          if (w_handshake && (i_req_expr != EXPR_IDLE)) begin
            r_expr     <= expr_e'(i_req_expr);
            r_idle_cnt <= '0;
            r_state    <= S_ARM;
            r_busy     <= 1'b1;
          end else if (w_frame_start) begin
            if (r_idle_cnt == IDLE_LAST) begin
              r_expr     <= EXPR_BLINK;
              r_idle_cnt <= '0;
              r_state    <= S_ARM;
              r_busy     <= 1'b1;
            end else begin
              r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
          end
        end
        S_ARM: begin
          if (w_frame_start) begin
            r_src_sel   <= r_expr;
            r_frame_idx <= 4'd0;
            r_hold_cnt  <= '0;
            r_state     <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (w_frame_start) begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_hold_cnt <= '0;
              if (r_frame_idx < STEP_LAST) begin
                r_frame_idx <= r_frame_idx + 4'd1;
              end else begin
                r_state <= S_RETURN;
              end
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
        end
        S_RETURN: begin
          if (w_frame_start) begin
            r_src_sel   <= 2'd0;
            r_frame_idx <= 4'd0;
            r_idle_cnt  <= '0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_src_sel   <= 2'd0;
          r_frame_idx <= 4'd0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/expression_scheduler.md
# expression_scheduler

Sequences the LCD face animation. It accepts expression requests over a valid/ready handshake and watches the pixel address stream the SPI LCD driver fetches. It drives the source-select and frame-index lines that the pixel mux and the expression ROMs consume. Source changes take effect only at a frame boundary, so a frame never shows two expressions (no tearing). When no request arrives, it inserts an automatic blink.

## Interface
- LCD_W, 132, pixel columns per frame
- LCD_H, 162, pixel rows per frame
- HOLD_FRAMES, 8, frames each animation step is displayed
- NUM_STEPS, 4, steps per expression animation (frame_idx 0..NUM_STEPS-1)
- IDLE_BLINK_FRAMES, 120, idle frames before an automatic BLINK

- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- go  in  1  run enable; 0 freezes all frame counters and holds outputs
- req_valid  in  1  expression request valid
- req_expr  in  2  requested expression code: 0 IDLE, 1 SMILE, 2 BLINK, 3 SLEEP
- req_ready  out  1  request accepted when req_valid & req_ready
- pix_x  in  8  current LCD fetch column (from LCD driver)
- pix_y  in  8  current LCD fetch row
- src_sel  out  2  expression source driving the pixel mux
- frame_idx  out  4  animation step within the selected expression
- frame_tick  out  1  one-cycle pulse at each frame start
- busy  out  1  1 in any state other than S_IDLE
- done  out  1  one-cycle pulse when an animation completes

## Operation
- Frame start: pix_x==0 && pix_y==0 this cycle, and the registered previous (x,y) was not (0,0). Gives one pulse per frame, even if the address dwells at (0,0).
- frame_tick is asserted only when go=1. When go=0, ticks are suppressed and no counter advances.
- S_IDLE:
  - req_ready=1, src_sel=0, frame_idx=0.
  - idle_cnt increments on each frame_tick.
  - On handshake with req_expr≠0: latch expr, clear idle_cnt, go to S_ARM.
  - On handshake with req_expr=0: accepted, no state change.
  - When idle_cnt reaches IDLE_BLINK_FRAMES-1 on a tick: latch BLINK, go to S_ARM.
  - Handshake and idle trigger in the same cycle: the handshake wins.
- S_ARM: req_ready=0. On frame_tick: src_sel←expr, frame_idx←0, hold_cnt←0, go to S_PLAY.
- S_PLAY: on each frame_tick, hold_cnt increments. When hold_cnt==HOLD_FRAMES-1:
  - hold_cnt←0.
  - If frame_idx<NUM_STEPS-1, frame_idx increments.
  - Otherwise go to S_RETURN.
- S_RETURN: on frame_tick: src_sel←0, frame_idx←0, done=1 for that cycle, go to S_IDLE (idle_cnt=0).
- Requests presented while busy are stalled (req_ready=0), never dropped. The requester holds req_valid.
- Async reset at any time: state S_IDLE, all counters 0. Outputs: req_ready=1, src_sel=0, frame_idx=0, frame_tick=0, busy=0, done=0. The previous-address register resets to (0,0), so the first (0,0) after reset is not a frame start.
- Counters saturate at their terminal value. idle_cnt and hold_cnt are sized $clog2 of their limit, minimum width 1.

## Timing
- All outputs are registered except req_ready. req_ready is a decode of state.
- Handshake at edge N: busy=1 and req_ready=0 from N+1.
- frame_tick asserts the cycle after the (0,0) address is sampled.
- src_sel and frame_idx change in the same cycle as frame_tick, so the pixel mux sees the new source from the first fetch after (0,0).
- done coincides with the frame_tick that restores src_sel=0.
- A full animation lasts 1 (arm) + NUM_STEPS·HOLD_FRAMES + 1 (return) frame ticks.

## Structure
- anim_pkg holds:
  - expression codes EXPR_IDLE/SMILE/BLINK/SLEEP
  - state encoding S_IDLE/S_ARM/S_PLAY/S_RETURN
  - default LCD_W/LCD_H, shared with the pixel mux and LCD top
- Sub-module frame_start_detect (pix_x, pix_y, go → frame_tick), reusable by other frame-synchronous blocks.

## Test plan
- Reset, then sweep the full frame, go=1, no request → frame_tick once per frame; no blink before tick 120; BLINK armed on tick 120; src_sel=2 on tick 121.
- req_expr=1 accepted mid-frame (x=40,y=70) → src_sel stays 0 until next (0,0); then src_sel=1, frame_idx 0→3, one step per 8 ticks; done pulse and src_sel=0 on tick 33 after arm.
- Second request (SLEEP) held valid during SMILE → req_ready=0 throughout; accepted the cycle after return to S_IDLE.
- go=0 for 5 frames during S_PLAY at frame_idx=2 → no ticks; frame_idx and hold_cnt frozen; resume continues exactly.
- Address held at (0,0) for 10 cycles → one frame_tick only.
- rst_n low mid-S_PLAY (async, between edges) → all outputs at reset values immediately; post-reset first (0,0) gives no tick.
